// File: rtl/exc_pkg.sv
// Shared exception codes, FSM state encoding and per-stage exception record
// for the exception/interrupt sequencer.
package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRAP,
    ST_ERET
  } exc_state_t;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
  } exc_rec_t;

  // An instruction keeps the first exception it raised; later stages only fill an empty slot.
  function automatic logic [4:0] first_exc(input logic [4:0] carried, input logic [4:0] local_code);
    return (carried != EXC_INT) ? carried : local_code;
  endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One pipeline exception record register with flush, bubble and load controls.
// Flush wins over bubble, which wins over load; with none asserted the record holds.
module exc_stage_reg
  import exc_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     bubble,
  input  logic     flush,
  input  exc_rec_t d,
  output exc_rec_t q
);

  // A bubble keeps pc/bd so an interrupt taken on it still saves a real return address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (bubble) begin
      q <= '{code: EXC_INT, pc: d.pc, bd: d.bd, eret: 1'b0};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exc_flow_ctrl.sv
// Exception/interrupt sequencer: carries first-raised exception info from D to M,
// presents it to CP0, and sequences the trap / eret flush-redirect handshakes.
module exc_flow_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic [4:0]  f_exc,
  input  logic [31:0] f_pc,
  input  logic        f_bd,
  input  logic [4:0]  d_exc,
  input  logic        d_eret,
  input  logic [4:0]  e_exc,
  input  logic [4:0]  m_exc,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  m_exc_code,
  output logic [31:0] m_pc,
  output logic        m_bd,
  output logic        eret_clr,
  output logic        flush_all,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  exc_state_t  state, state_next;
  exc_rec_t    f_rec, d_q, d_fwd, e_q, e_fwd, m_q;
  logic [31:0] epc_q;
  logic        eret_take;
  logic        unused_d_eret;

  assign f_rec         = '{code: f_exc, pc: f_pc, bd: f_bd, eret: 1'b0};
  assign unused_d_eret = d_q.eret;

  // eret is decoded in D and only counts when the instruction has not already faulted.
  always_comb begin
    d_fwd      = d_q;
    d_fwd.code = first_exc(d_q.code, d_exc);
    d_fwd.eret = d_eret && (d_q.code == EXC_INT) && (d_exc == EXC_INT);
  end

  always_comb begin
    e_fwd      = e_q;
    e_fwd.code = first_exc(e_q.code, e_exc);
  end

  exc_stage_reg u_d_rec (
    .clk    (clk),
    .reset  (reset),
    .load   (!stall_d),
    .bubble (1'b0),
    .flush  (flush_all),
    .d      (f_rec),
    .q      (d_q)
  );

  exc_stage_reg u_e_rec (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (stall_d),
    .flush  (flush_all),
    .d      (d_fwd),
    .q      (e_q)
  );

  exc_stage_reg u_m_rec (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (1'b0),
    .flush  (flush_all),
    .d      (e_fwd),
    .q      (m_q)
  );

  // A trap request always beats an eret reaching M in the same cycle.
  assign eret_take = !cp0_req && m_q.eret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      epc_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_RUN && eret_take) begin
        epc_q <= cp0_epc;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (cp0_req) begin
          state_next = ST_TRAP;
        end else if (m_q.eret) begin
          state_next = ST_ERET;
        end
      end
      ST_TRAP: state_next = ST_RUN;
      ST_ERET: state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // During the redirect cycle the exception code is held at 0 so CP0 cannot re-trap.
  always_comb begin
    m_exc_code  = EXC_INT;
    m_pc        = m_q.pc;
    m_bd        = m_q.bd;
    eret_clr    = 1'b0;
    flush_all   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      ST_RUN: begin
        m_exc_code = first_exc(m_q.code, m_exc);
        flush_all  = cp0_req || m_q.eret;
        eret_clr   = eret_take;
      end
      ST_TRAP: begin
        flush_all   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = HANDLER_PC;
      end
      ST_ERET: begin
        flush_all   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_q;
      end
      default: begin
        m_exc_code = EXC_INT;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_flow_ctrl.sv
// Scoreboard bench for exc_flow_ctrl: stimulus pushes expected CP0/flush/redirect
// snapshots, a negedge monitor pops one whenever the DUT flushes, redirects or clears EXL.
`timescale 1ns/1ps
module tb_exc_flow_ctrl;
  import exc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d;
  logic [4:0]  f_exc, d_exc, e_exc, m_exc;
  logic [31:0] f_pc, cp0_epc;
  logic        f_bd, d_eret, cp0_req, int_req;
  logic [4:0]  m_exc_code;
  logic [31:0] m_pc, redirect_pc;
  logic        m_bd, eret_clr, flush_all, redirect;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        clr;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] HPC = 32'h0000_4180;

  exc_flow_ctrl #(.HANDLER_PC(HPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_d     (stall_d),
    .f_exc       (f_exc),
    .f_pc        (f_pc),
    .f_bd        (f_bd),
    .d_exc       (d_exc),
    .d_eret      (d_eret),
    .e_exc       (e_exc),
    .m_exc       (m_exc),
    .cp0_req     (cp0_req),
    .cp0_epc     (cp0_epc),
    .m_exc_code  (m_exc_code),
    .m_pc        (m_pc),
    .m_bd        (m_bd),
    .eret_clr    (eret_clr),
    .flush_all   (flush_all),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Behaves like CP0: request on any exception code presented, or on an interrupt.
  assign cp0_req = (m_exc_code != EXC_INT) || int_req;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                              input logic clr, input logic flush, input logic redir,
                              input logic [31:0] rpc);
    exp_t e;
    e.code = code; e.pc = pc; e.bd = bd; e.clr = clr;
    e.flush = flush; e.redir = redir; e.rpc = rpc;
    return e;
  endfunction

  // A trap is the flush cycle that CP0 commits, followed by the handler redirect cycle.
  task automatic push_trap(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    sb.push_back(mk(code, pc, bd, 1'b0, 1'b1, 1'b0, 32'h0));
    sb.push_back(mk(EXC_INT, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, HPC));
  endtask

  always @(negedge clk) begin
    if (!reset && (flush_all || redirect || eret_clr)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_event: actual flush=%b redirect=%b eret_clr=%b required none",
                 flush_all, redirect, eret_clr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("m_exc_code",  32'(m_exc_code), 32'(e.code));
        check_output("m_pc",        m_pc,            e.pc);
        check_output("m_bd",        32'(m_bd),       32'(e.bd));
        check_output("eret_clr",    32'(eret_clr),   32'(e.clr));
        check_output("flush_all",   32'(flush_all),  32'(e.flush));
        check_output("redirect",    32'(redirect),   32'(e.redir));
        check_output("redirect_pc", redirect_pc,     e.rpc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_idle();
    stall_d = 1'b0; f_exc = '0; f_pc = '0; f_bd = 1'b0;
    d_exc = '0; d_eret = 1'b0; e_exc = '0; m_exc = '0;
    cp0_epc = '0; int_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_m_exc_code"},  32'(m_exc_code), 32'h0);
    check_output({tag, "_m_pc"},        m_pc,            32'h0);
    check_output({tag, "_m_bd"},        32'(m_bd),       32'h0);
    check_output({tag, "_eret_clr"},    32'(eret_clr),   32'h0);
    check_output({tag, "_flush_all"},   32'(flush_all),  32'h0);
    check_output({tag, "_redirect"},    32'(redirect),   32'h0);
    check_output({tag, "_redirect_pc"}, redirect_pc,     32'h0);
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus_idle();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick(); tick();

    // Overflow in E at 0x3010: CP0 sees it one cycle later, redirect the cycle after.
    f_pc = 32'h3010; tick();
    f_pc = 32'h3014; tick();
    e_exc = EXC_OV; push_trap(EXC_OV, 32'h3010, 1'b0); tick();
    e_exc = '0; tick(); tick(); tick();

    // Fetch AdEL keeps priority over a later RI, and suppresses the eret decode.
    f_pc = 32'h3100; f_exc = EXC_ADEL; tick();
    f_pc = 32'h3104; f_exc = '0; d_exc = EXC_RI; d_eret = 1'b1;
    push_trap(EXC_ADEL, 32'h3100, 1'b0); tick();
    f_pc = '0; d_exc = '0; d_eret = 1'b0; tick();
    tick(); tick(); tick();

    // Syscall in D (delay slot) keeps priority over a later overflow in E.
    f_pc = 32'h3200; f_bd = 1'b1; tick();
    f_pc = '0; f_bd = 1'b0; d_exc = EXC_SYSCALL; tick();
    d_exc = '0; e_exc = EXC_OV; push_trap(EXC_SYSCALL, 32'h3200, 1'b1); tick();
    e_exc = '0; tick(); tick(); tick();

    // Memory-stage AdES goes straight through to CP0 in the same cycle.
    f_pc = 32'h3300; tick();
    f_pc = '0; tick(); tick();
    m_exc = EXC_ADES; push_trap(EXC_ADES, 32'h3300, 1'b0); tick();
    m_exc = '0; tick(); tick();

    // Two-cycle stall: interrupt on the bubble reports the held instruction's pc/bd.
    f_pc = 32'h3020; f_bd = 1'b1; tick();
    f_pc = 32'h3024; f_bd = 1'b0; stall_d = 1'b1; tick();
    tick();
    stall_d = 1'b0; f_pc = '0; int_req = 1'b1; push_trap(EXC_INT, 32'h3020, 1'b1); tick();
    int_req = 1'b0; tick(); tick();

    // eret: EXLClr pulse, latched EPC redirect, then an interrupt held over ERET.
    f_pc = 32'h3500; tick();
    f_pc = '0; d_eret = 1'b1; tick();
    d_eret = 1'b0; tick();
    cp0_epc = 32'h3400;
    sb.push_back(mk(EXC_INT, 32'h3500, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
    tick();
    cp0_epc = 32'h9999; int_req = 1'b1;
    sb.push_back(mk(EXC_INT, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3400));
    push_trap(EXC_INT, 32'h0, 1'b0);
    tick(); tick();
    int_req = 1'b0; cp0_epc = '0; tick(); tick();

    // eret together with an interrupt request: the trap wins.
    f_pc = 32'h3600; tick();
    f_pc = '0; d_eret = 1'b1; tick();
    d_eret = 1'b0; tick();
    cp0_epc = 32'h3400; int_req = 1'b1; push_trap(EXC_INT, 32'h3600, 1'b0); tick();
    int_req = 1'b0; cp0_epc = '0; tick(); tick();

    // Reset asserted during the TRAP cycle clears everything immediately.
    f_pc = 32'h3700; tick();
    f_pc = '0; tick(); tick();
    m_exc = EXC_ADEL;
    sb.push_back(mk(EXC_ADEL, 32'h3700, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tick();
    m_exc = '0; reset = 1'b1;
    #1;
    check_all_zero("trap_reset");
    tick();
    reset = 1'b0;
    tick(); tick(); tick();

    check_output("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_flow_ctrl.md
# exc_flow_ctrl

Exception/interrupt sequencer for the five-stage pipeline. It carries each instruction's first-raised exception code, PC and delay-slot flag from D through M, and presents them to CP0 at M. It sequences the trap and `eret` handshakes: flush, one registered redirect cycle, and the `EXLClr` pulse. It sits beside the stage registers and drives their flush and the NPC redirect mux.

## Interface
- `HANDLER_PC`, default `32'h0000_4180`: handler entry address.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `stall_d`  in  1  hazard stall; F/D holds and a bubble is sent to E.
- `f_exc`  in  5  fetch exception (AdEL=4), valid with the F→D transfer.
- `f_pc`  in  32  PC of the F-stage instruction.
- `f_bd`  in  1  F-stage instruction is in a delay slot.
- `d_exc`  in  5  decode exception (RI=10, Syscall=8).
- `d_eret`  in  1  D-stage instruction is `eret`.
- `e_exc`  in  5  execute exception (Ov=12, AdEL=4, AdES=5).
- `m_exc`  in  5  memory exception (AdEL=4, AdES=5).
- `cp0_req`  in  1  CP0 `Req`, combinational from `m_exc_code`/HWInt.
- `cp0_epc`  in  32  CP0 `EPCOut`.
- `m_exc_code`  out  5  to CP0 `ExcCodeIn`; reset 0.
- `m_pc`  out  32  to CP0 `PC`; reset 0.
- `m_bd`  out  1  to CP0 `isInDelaySlot`; reset 0.
- `eret_clr`  out  1  to CP0 `EXLClr`; reset 0.
- `flush_all`  out  1  clears the F/D, D/E and E/M stage registers; reset 0.
- `redirect`  out  1  NPC takes `redirect_pc`; reset 0.
- `redirect_pc`  out  32  reset 0.

## Operation
- Per-stage records D, E, M, each holding `{code[4:0], pc[31:0], bd, eret}`. All fields reset to 0.
- First-exception rule: a stage adds its own exception only if the carried code is 0.
  - D.code ← `f_exc`.
  - E.code ← D.code or `d_exc`.
  - M.code ← E.code or `e_exc`.
  - `m_exc_code` = M.code if it is non-zero, otherwise `m_exc`.
- `eret` is recorded in D.eret only when D.code is 0 and `d_exc` is 0.
- When `stall_d` is high, D holds and E loads a bubble.
  - The bubble has code 0 and eret 0.
  - The bubble carries the pc/bd of the held D instruction, so an interrupt taken on the bubble saves the EPC of the next real instruction.
- `m_pc` and `m_bd` are driven from the M record.
- FSM states: RUN, TRAP, ERET.
  - RUN, `cp0_req` high: `flush_all`=1 combinationally; next state TRAP.
  - RUN, `cp0_req` low and M.eret=1: `eret_clr`=1 and `flush_all`=1; latch `cp0_epc` into `epc_q`; next state ERET.
  - TRAP: `redirect`=1, `redirect_pc`=`HANDLER_PC`, `flush_all`=1; next state RUN.
  - ERET: `redirect`=1, `redirect_pc`=`epc_q`, `flush_all`=1; next state RUN.
- `flush_all` clears D/E/M records at the edge. Flush has priority over `stall_d`.
- In TRAP and ERET, `m_exc_code` is forced to 0. The records are already flushed, so at most an interrupt can re-request.

## Timing
- Exception path from `m_exc` through `m_exc_code` and `cp0_req` to `flush_all` is combinational within one cycle. CP0 commits EPC/EXL at that same edge.
- Redirect is registered: asserted exactly one cycle after the trap or `eret` cycle, for one cycle.
- Exception raised in E reaches CP0 one cycle later; raised in D, two cycles; raised in F, three cycles (absent stalls).
- `cp0_req` and M.eret in the same cycle: the trap wins and `eret_clr` stays 0. The `eret` re-executes after the handler returns.
- `cp0_req` while in TRAP or ERET: ignored, because `m_exc_code`=0 and EXL is already set (TRAP). In ERET, an interrupt request is honored in the following RUN cycle.
- Asynchronous reset at any time: state RUN, all records, `epc_q` and outputs 0 immediately.

## Structure
- Shared package `exc_pkg`:
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - FSM state enum.
  - `HANDLER_PC` default.
- Natural sub-module: `exc_stage_reg`, one record register with load/bubble/flush controls, instantiated ×3.

## Test plan
- Overflow (`e_exc`=12) on an instruction at `0x3010` → the next cycle `m_exc_code`=12, `m_pc`=`0x3010`, and `flush_all` is high. The cycle after that, `redirect`=1 and `redirect_pc`=`0x4180`.
- `f_exc`=4 and later `d_exc`=10 on the same instruction → `m_exc_code`=4; the RI code is dropped.
- `stall_d` for 2 cycles with D instruction at `0x3020` and `bd`=1, plus `cp0_req` on the bubble → `m_pc`=`0x3020` and `m_bd`=1.
- `eret` reaches M with `cp0_epc`=`0x3400` → `eret_clr` pulses for 1 cycle; next cycle `redirect_pc`=`0x3400`.
- `eret` in M together with `cp0_req` → `eret_clr`=0 and `redirect_pc`=`0x4180`.
- Assert `reset` during the TRAP cycle → `redirect`=0 immediately; state RUN; all outputs 0.
